// File: rtl/bcd_adder_serial_n_digits.sv
// ---------------------------------------------------------------------------
// bcd_adder_serial_n_digits
//
// Sequential multi-digit BCD adder. Two packed BCD operands are captured on
// a start strobe and summed one digit per clock, least-significant first,
// using the 1-digit rule: if the binary digit sum exceeds 9, subtract 10 and
// carry. Results are presented under a start/busy/done handshake.
//
// Parameters:
//   DIGITS  number of BCD digits per operand (1..16)
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high reset
//   start   request strobe, sampled only while idle
//   X, Y    packed BCD operands, digit i at [4i+3:4i]
//   cin     carry into digit 0
//   sub     subtract mode (only when BCD_SUB_EN is defined)
//   busy    high while digits are being processed
//   done    one-cycle pulse when S/cout/error are valid
//   S       packed BCD sum
//   cout    carry out of the most significant digit
//   error   a captured operand digit was greater than 9
//
// Optional feature macro: BCD_SUB_EN (adds the sub input; nines-complement
// subtraction with forced initial carry).
// ---------------------------------------------------------------------------
module bcd_adder_serial_n_digits #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   X,
  input  logic [4*DIGITS-1:0]   Y,
  input  logic                  cin,
`ifdef BCD_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   S,
  output logic                  cout,
  output logic                  error
);

  localparam int IDX_W = $clog2(DIGITS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  a_q;
  logic [4*DIGITS-1:0]  b_q;
  logic                 c_q;
  logic [IDX_W-1:0]     idx;
  logic [4:0]           dsum;
  logic                 sub_now;

  // One BCD digit step: returns {carry, digit}. For t in 10..19 the low
  // nibble of t-10 equals t[3:0]-10 modulo 16.
  function automatic logic [4:0] digit_add(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       c);
    logic [4:0] t;
    t = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (t > 5'd9)
      return {1'b1, t[3:0] - 4'd10};
    else
      return {1'b0, t[3:0]};
  endfunction

  function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [4*DIGITS-1:0] nines(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++)
      r[4*k +: 4] = 4'd9 - v[4*k +: 4];
    return r;
  endfunction

`ifdef BCD_SUB_EN
  assign sub_now = sub;
`else
  assign sub_now = 1'b0;
`endif

  // Operands are shifted right each ADD cycle, so the current digit is
  // always in the low nibble.
  assign dsum = digit_add(a_q[3:0], b_q[3:0], c_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      cout  <= 1'b0;
      error <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= X;
            b_q  <= sub_now ? nines(Y) : Y;
            c_q  <= sub_now ? 1'b1 : cin;
            idx  <= '0;
            S    <= '0;
            cout <= 1'b0;
            // The check looks at the raw Y digits, before any complementing.
            if (has_bad(X) || has_bad(Y)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b0;
              busy  <= 1'b1;
              state <= ADD;
            end
          end
        end
        ADD: begin
          for (int k = 0; k < DIGITS; k++)
            if (idx == IDX_W'(k)) S[4*k +: 4] <= dsum[3:0];
          a_q <= a_q >> 4;
          b_q <= b_q >> 4;
          c_q <= dsum[4];
          idx <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout  <= dsum[4];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_adder_serial_n_digits.sv
// ---------------------------------------------------------------------------
// Testbench for bcd_adder_serial_n_digits (DIGITS=4 main instance plus a
// DIGITS=1 instance). A decimal-arithmetic model predicts results; one
// monitor process compares every cycle, and directed vectors carry
// hand-computed literal results as well.
// ---------------------------------------------------------------------------
module tb_bcd_adder_serial_n_digits;

  localparam int D = 4;
`ifdef BCD_SUB_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, cin, sub;
  logic [15:0] X, Y;
  logic        busy, done, cout, error;
  logic [15:0] S;

  logic        start1, cin1, sub1;
  logic [3:0]  x1, y1;
  logic        busy1, done1, cout1, error1;
  logic [3:0]  s1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // shared expectation state for the monitor
  int          c0;
  bit          active   = 1'b0;
  bit          zero_exp = 1'b1;
  bit          mon_en   = 1'b0;
  logic [15:0] exp_s;
  logic        exp_c, exp_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_adder_serial_n_digits #(.DIGITS(D)) dut (
    .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y), .cin(cin),
`ifdef BCD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .S(S), .cout(cout), .error(error)
  );

  bcd_adder_serial_n_digits #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .X(x1), .Y(y1), .cin(cin1),
`ifdef BCD_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .S(s1), .cout(cout1), .error(error1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit valid_bcd(input logic [15:0] v);
    for (int k = 0; k < 4; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r;
    r[3:0]   = 4'(n % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[15:12] = 4'((n / 1000) % 10);
    return r;
  endfunction

  // Decimal model: plain integer addition modulo 10^4.
  task automatic model(input logic [15:0] x, y, input logic ci, sb,
                       output logic [15:0] s, output logic co, er);
    int a, b, t;
    er = !(valid_bcd(x) && valid_bcd(y));
    if (er) begin
      s = '0; co = 1'b0;
    end else begin
      a = bcd2int(x);
      b = bcd2int(y);
      if (sb) t = a + (9999 - b) + 1;
      else    t = a + b + int'(ci);
      co = (t >= 10000);
      s  = int2bcd(t % 10000);
    end
  endtask

  // Monitor: timing of busy/done and held results on every cycle.
  always @(negedge clk) begin
    int k, last;
    if (mon_en) begin
      if (active) begin
        k    = cyc - c0 + 1;
        last = exp_e ? 1 : D + 1;
        chk("busy", 32'(busy), 32'(!exp_e && k <= D));
        chk("done", 32'(done), 32'(k == last));
        if (k >= last) begin
          chk("S", 32'(S), 32'(exp_s));
          chk("cout", 32'(cout), 32'(exp_c));
          chk("error", 32'(error), 32'(exp_e));
        end
      end else if (zero_exp) begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_S", 32'(S), 0);
        chk("idle_cout", 32'(cout), 0);
        chk("idle_error", 32'(error), 0);
      end
    end
  end

  // Issue one operation. pulse_at>0 pulses start in that cycle; rst_at>0
  // asserts reset in that cycle and discards the operation.
  task automatic op(input logic [15:0] x, y, input logic ci, sb,
                    input logic [15:0] ls, input logic lc, le,
                    input int pulse_at, rst_at);
    int last;
    X = x; Y = y; cin = ci; sub = sb & SUB_ON; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(x, y, ci, sub, exp_s, exp_c, exp_e);
    X = 16'($urandom); Y = 16'($urandom); cin = 1'($urandom); sub = 1'b0;
    c0 = cyc; active = 1'b1; zero_exp = 1'b0;
    last = exp_e ? 1 : D + 1;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      start = (n == pulse_at);
      if (n == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        active = 1'b0; zero_exp = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        return;
      end
    end
    chk("lit_S", 32'(S), 32'(ls));
    chk("lit_cout", 32'(cout), 32'(lc));
    chk("lit_error", 32'(error), 32'(le));
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; X = 16'h1234; Y = 16'h5678; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; x1 = 4'd0; y1 = 4'd0; cin1 = 1'b0; sub1 = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);

    op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0, 0);
    op(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 0);
    op(16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 0, 0);
    op(16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 0);
    op(16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 0);
    op(16'h0000, 16'h000F, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 0);
    op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 0, 2);
    op(16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 3, 0);
    op(16'h0500, 16'h0499, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, D + 1, 0);
    op(16'h2718, 16'h3141, 1'b1, 1'b0, 16'h5860, 1'b0, 1'b0, 0, 0);
`ifdef BCD_SUB_EN
    op(16'h5000, 16'h1234, 1'b0, 1'b1, 16'h3766, 1'b1, 1'b0, 0, 0);
    op(16'h1234, 16'h5000, 1'b1, 1'b1, 16'h6234, 1'b0, 1'b0, 0, 0);
    op(16'h4321, 16'h4321, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0, 0);
    op(16'h0001, 16'h00B0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 0);
`endif

    // single-digit instance
    @(negedge clk);
    x1 = 4'd7; y1 = 4'd5; cin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("d1_busy_c1", 32'(busy1), 1);
    chk("d1_done_c1", 32'(done1), 0);
    @(negedge clk);
    chk("d1_done_c2", 32'(done1), 1);
    chk("d1_busy_c2", 32'(busy1), 0);
    chk("d1_S", 32'(s1), 2);
    chk("d1_cout", 32'(cout1), 1);
    chk("d1_error", 32'(error1), 0);
    @(negedge clk);
    chk("d1_done_c3", 32'(done1), 0);
    x1 = 4'hA; y1 = 4'd1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    chk("d1_err_done", 32'(done1), 1);
    chk("d1_err_error", 32'(error1), 1);
    chk("d1_err_busy", 32'(busy1), 0);
    chk("d1_err_S", 32'(s1), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
